// File: rtl/mch_pkg.sv
// Shared Manchester codec definitions: FSM encodings, error codes, default frame width.
package mch_pkg;
  localparam int MCH_DATA_W = 16;

  typedef enum logic [1:0] {
    MCH_RECOVER = 2'd0,
    MCH_IDLE    = 2'd1,
    MCH_RUN     = 2'd2
  } mch_state_e;

  localparam logic [1:0] MCH_ERR_SHORT = 2'd1;
  localparam logic [1:0] MCH_ERR_OVR   = 2'd2;
  localparam logic [1:0] MCH_ERR_PAR   = 2'd3;
endpackage

// File: rtl/mch_rx_sync.sv
// 2-FF synchronizer for rxsd with registered level and rise/fall pulses (3 clocks pin-to-pulse).
module mch_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rxsd,
  output logic lvl,
  output logic rise,
  output logic fall
);
  logic s1, s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      lvl  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= rxsd;
      s2   <= s1;
      lvl  <= s2;
      rise <= s2 & ~lvl;
      fall <= ~s2 & lvl;
    end
  end
endmodule

// File: rtl/mch_rx_decoder.sv
// Manchester frame receiver: mid-bit edge windowing, framing checks, one-cycle valid/err strobes.
// Optional even parity bit after the data word when MCH_RX_PARITY_EN is defined.
module mch_rx_decoder
  import mch_pkg::*;
#(
  parameter int BIT_CLKS = 100,
  parameter int DATA_W   = MCH_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxsd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_err,
  output logic [1:0]        err_code,
  output logic              busy
);
`ifdef MCH_RX_PARITY_EN
  localparam int FRAME_BITS = DATA_W + 1;
`else
  localparam int FRAME_BITS = DATA_W;
`endif
  localparam int CW = $clog2(2*BIT_CLKS+1);
  localparam int NW = $clog2(FRAME_BITS+1);
  localparam logic [CW-1:0] WIN_LO = CW'(3*BIT_CLKS/4);
  localparam logic [CW-1:0] WIN_HI = CW'(5*BIT_CLKS/4);
  localparam logic [CW-1:0] WIN_TO = CW'(5*BIT_CLKS/4 + 1);
  localparam logic [CW-1:0] CMAX   = CW'(2*BIT_CLKS);
  localparam logic [NW-1:0] NFRAME = NW'(FRAME_BITS);

  mch_state_e          st;
  logic [CW-1:0]       cnt;
  logic [NW-1:0]       nbits;
  logic [FRAME_BITS-1:0] sh;
  logic                lvl, rise, fall;
  logic                mid_edge, par_ok;
  logic [DATA_W-1:0]   word;

  mch_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rxsd (rxsd),
    .lvl  (lvl),
    .rise (rise),
    .fall (fall)
  );

  // Edges before WIN_LO are bit-boundary transitions and carry no data.
  assign mid_edge = (rise | fall) && (cnt >= WIN_LO) && (cnt <= WIN_HI);

`ifdef MCH_RX_PARITY_EN
  assign par_ok = ~^sh;
  assign word   = sh[FRAME_BITS-1:1];
`else
  assign par_ok = 1'b1;
  assign word   = sh;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= MCH_RECOVER;
      cnt      <= '0;
      nbits    <= '0;
      sh       <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      err_code <= '0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      case (st)
        MCH_RECOVER: begin
          if (lvl)              cnt <= '0;
          else if (cnt == CMAX) st  <= MCH_IDLE;
          else                  cnt <= cnt + 1'b1;
        end
        MCH_IDLE: begin
          if (rise) begin
            cnt   <= '0;
            nbits <= '0;
            busy  <= 1'b1;
            st    <= MCH_RUN;
          end
        end
        MCH_RUN: begin
          if (cnt != CMAX) cnt <= cnt + 1'b1;
          if (mid_edge) begin
            cnt <= '0;
            if (nbits == NFRAME) begin
              rx_err   <= 1'b1;
              err_code <= MCH_ERR_OVR;
              busy     <= 1'b0;
              st       <= MCH_RECOVER;
            end else begin
              sh    <= {sh[FRAME_BITS-2:0], rise};
              nbits <= nbits + 1'b1;
            end
          end else if (cnt == WIN_TO) begin
            // No mid-bit edge inside the window: the frame has ended.
            cnt  <= '0;
            busy <= 1'b0;
            if (nbits == NFRAME && !lvl && par_ok) begin
              rx_valid <= 1'b1;
              rx_data  <= word;
              st       <= MCH_IDLE;
            end else begin
              rx_err   <= 1'b1;
              err_code <= (nbits != NFRAME || lvl) ? MCH_ERR_SHORT : MCH_ERR_PAR;
              st       <= MCH_RECOVER;
            end
          end
        end
        default: st <= MCH_RECOVER;
      endcase
    end
  end
endmodule

// File: doc/mch_rx_decoder.md
# mch_rx_decoder

Manchester line decoder for the `mch_codec` serial link: recovers 16-bit frames from the `rxsd` line (IEEE 802.3 convention: `1` = low→high at mid-bit, `0` = high→low), checks framing, and presents each word with a one-cycle valid strobe. It is the receive end of the link driven by the codec's `txsd` encoder and sits between the board `rxsd` pin and the 7-segment/LED display logic.

## Interface

- `BIT_CLKS`, 100: clocks per Manchester bit period (1 Mbps at 100 MHz); must be ≥ 8.
- `DATA_W`, 16: data bits per frame, MSB first.
- `clk` in 1: 100 MHz system clock.
- `rst` in 1: synchronous, active-high reset.
- `rxsd` in 1: asynchronous serial line; idles low.
- `rx_data` out DATA_W: last good frame; changes only with `rx_valid`.
- `rx_valid` out 1: one-cycle pulse; good frame in `rx_data`.
- `rx_err` out 1: one-cycle pulse; frame discarded.
- `err_code` out 2: cause, valid with `rx_err`: 1 = short frame, 2 = overrun, 3 = parity; held until next `rx_err`.
- `busy` out 1: high in RUN.

## Operation

- Frame on the wire: start bit (`1`), DATA_W data bits MSB first, optional parity bit, then line low ≥ 2 bit periods.
- `rxsd` passes through a 2-FF synchronizer (reset 0), then edge detection on the synchronized value; edges are seen by the FSM 3 clocks after the pin changes.
- Window constants: `WIN_LO = 3*BIT_CLKS/4`, `WIN_HI = 5*BIT_CLKS/4`. Counter `cnt` is `$clog2(2*BIT_CLKS+1)` bits wide and saturates.
- FSM states:
  - **RECOVER**: `cnt` counts while the line is low and clears on high. At `cnt == 2*BIT_CLKS`, go to IDLE.
  - **IDLE**: a rising edge is the start bit's mid-bit edge. Clear `cnt`, clear `nbits`, go to RUN.
  - **RUN**: edges with `cnt < WIN_LO` are boundary edges and are ignored. An edge with `WIN_LO ≤ cnt ≤ WIN_HI` is a mid-bit edge: shift in its polarity (rising = 1), increment `nbits`, clear `cnt`.
    - If `nbits` would exceed `FRAME_BITS`, raise `rx_err` with code 2 and go to RECOVER.
    - If `cnt` reaches WIN_HI+1 with no edge, end of frame:
      - `nbits == FRAME_BITS`, line low, and parity OK: `rx_valid`, `rx_data` loaded, go to IDLE.
      - Short frame or line high: `rx_err` code 1, go to RECOVER.
      - Parity fail: `rx_err` code 3, go to RECOVER.
- `rx_valid` and `rx_err` are never high in the same cycle.

## Timing

- Reset (any state, mid-frame included) → RECOVER. Reset values: `cnt = 0`, shift register 0, `rx_data = 0`, `rx_valid = 0`, `rx_err = 0`, `err_code = 0`, `busy = 0`. After reset, the line must be idle low for 2*BIT_CLKS before a frame is accepted.
- `rst` has priority over every event in the same cycle.
- `rx_valid`/`rx_err` are registered. They assert on the clock after `cnt` hits WIN_HI+1, i.e. WIN_HI+2 clocks after the last accepted synchronized edge.
- An edge arriving exactly when `cnt == WIN_HI` is accepted; the timeout does not fire.
- A back-to-back frame whose start edge arrives after `rx_valid` in IDLE is accepted. A start edge during the timeout cycle is lost; the transmitter gap is ≥ 2 bits.

## Configuration

- `MCH_RX_PARITY_EN` defined: `FRAME_BITS = DATA_W+1`. The last bit is even parity over the data bits; a mismatch gives `err_code` 3.
- Not defined: `FRAME_BITS = DATA_W`, no parity logic, code 3 is never produced.

## Structure

- Shared `mch_pkg` holds:
  - FSM state encodings (RECOVER, IDLE, RUN).
  - `err_code` constants `MCH_ERR_SHORT`/`MCH_ERR_OVR`/`MCH_ERR_PAR`.
  - Default DATA_W. The encoder uses the same package.
- One sub-module, `mch_rx_sync`: 2-FF synchronizer plus registered rise/fall pulse outputs.

## Test plan

All scenarios use `BIT_CLKS = 100`.

- Reset, then 300 clocks of idle low, then send 0xA5C3 → one `rx_valid`, `rx_data = 0xA5C3`, `rx_err` never high.
- Send 0x0000 then 0xFFFF with a 2-bit gap (these have boundary edges on every bit) → two `rx_valid` pulses, data 0x0000 then 0xFFFF.
- Stop driving after 10 data bits, line held low → `rx_err`, `err_code = 1`; next clean frame 0x1234 is received correctly.
- Append an extra 17th (or 18th with parity) Manchester bit → `rx_err`, `err_code = 2`, `rx_data` unchanged.
- With `MCH_RX_PARITY_EN`: send 0x0001 with parity 0 → `err_code = 3`. Send 0x0001 with parity 1 → `rx_valid`.
- Assert `rst` at data bit 8 of a frame → all outputs 0 next cycle, that frame is dropped silently, and the following frame (after ≥ 2 bits idle) is received.
